// File: rtl/axi_ic_pkg.sv
// Shared types and constants for the 4x4 AXI interconnect.
package axi_ic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DERR = 2'd3
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int NUM_SLV = 4;

    localparam logic [63:0] DEF_S0_BASE = 64'h0000_0000_0000_0000;
    localparam logic [63:0] DEF_S1_BASE = 64'h0000_0000_1000_0000;
    localparam logic [63:0] DEF_S2_BASE = 64'h0000_0000_2000_0000;
    localparam logic [63:0] DEF_S3_BASE = 64'h0000_0000_3000_0000;
    localparam logic [63:0] DEF_MASK    = 64'hFFFF_FFFF_F000_0000;

endpackage

// File: rtl/axi_addr_decode.sv
// Base/mask window compare with lowest-index priority. Shared by read and write demux.
module axi_addr_decode
    import axi_ic_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] S0_BASE    = ADDR_WIDTH'(DEF_S0_BASE),
    parameter logic [ADDR_WIDTH-1:0] S1_BASE    = ADDR_WIDTH'(DEF_S1_BASE),
    parameter logic [ADDR_WIDTH-1:0] S2_BASE    = ADDR_WIDTH'(DEF_S2_BASE),
    parameter logic [ADDR_WIDTH-1:0] S3_BASE    = ADDR_WIDTH'(DEF_S3_BASE),
    parameter logic [ADDR_WIDTH-1:0] S0_MASK    = ADDR_WIDTH'(DEF_MASK),
    parameter logic [ADDR_WIDTH-1:0] S1_MASK    = ADDR_WIDTH'(DEF_MASK),
    parameter logic [ADDR_WIDTH-1:0] S2_MASK    = ADDR_WIDTH'(DEF_MASK),
    parameter logic [ADDR_WIDTH-1:0] S3_MASK    = ADDR_WIDTH'(DEF_MASK)
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [1:0]            sel_o,
    output logic                  hit_o
);

    localparam logic [ADDR_WIDTH-1:0] BASE_A [NUM_SLV] = '{S0_BASE, S1_BASE, S2_BASE, S3_BASE};
    localparam logic [ADDR_WIDTH-1:0] MASK_A [NUM_SLV] = '{S0_MASK, S1_MASK, S2_MASK, S3_MASK};

    // Scan from highest to lowest index so the lowest matching window wins.
    always_comb begin
        sel_o = 2'd0;
        hit_o = 1'b0;
        for (int k = NUM_SLV - 1; k >= 0; k--) begin
            if ((addr_i & MASK_A[k]) == BASE_A[k]) begin
                sel_o = 2'(k);
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_slave_demux_r.sv
// Read-channel demux: routes one AR/R transaction at a time to the decoded slave,
// or answers unmapped addresses with an internal DECERR burst.
module axi_slave_demux_r
    import axi_ic_pkg::*;
#(
    parameter int                    DATA_WIDTH = 1024,
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    ID_WIDTH   = 8,
    parameter int                    USER_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] S0_BASE    = ADDR_WIDTH'(DEF_S0_BASE),
    parameter logic [ADDR_WIDTH-1:0] S1_BASE    = ADDR_WIDTH'(DEF_S1_BASE),
    parameter logic [ADDR_WIDTH-1:0] S2_BASE    = ADDR_WIDTH'(DEF_S2_BASE),
    parameter logic [ADDR_WIDTH-1:0] S3_BASE    = ADDR_WIDTH'(DEF_S3_BASE),
    parameter logic [ADDR_WIDTH-1:0] S0_MASK    = ADDR_WIDTH'(DEF_MASK),
    parameter logic [ADDR_WIDTH-1:0] S1_MASK    = ADDR_WIDTH'(DEF_MASK),
    parameter logic [ADDR_WIDTH-1:0] S2_MASK    = ADDR_WIDTH'(DEF_MASK),
    parameter logic [ADDR_WIDTH-1:0] S3_MASK    = ADDR_WIDTH'(DEF_MASK)
) (
    input  logic                  clk,
    input  logic                  rstn,
    // upstream read address
    input  logic [ID_WIDTH-1:0]   s2m_ARID,
    input  logic [ADDR_WIDTH-1:0] s2m_ARADDR,
    input  logic [7:0]            s2m_ARLEN,
    input  logic [2:0]            s2m_ARSIZE,
    input  logic [1:0]            s2m_ARBURST,
    input  logic                  s2m_ARLOCK,
    input  logic [3:0]            s2m_ARCACHE,
    input  logic [2:0]            s2m_ARPROT,
    input  logic [3:0]            s2m_ARQOS,
    input  logic [3:0]            s2m_ARREGION,
    input  logic [USER_WIDTH-1:0] s2m_ARUSER,
    input  logic                  s2m_ARVALID,
    output logic                  s2m_ARREADY,
    // upstream read data
    output logic                  s2m_RVALID,
    output logic [ID_WIDTH-1:0]   s2m_RID,
    output logic [DATA_WIDTH-1:0] s2m_RDATA,
    output logic [1:0]            s2m_RRESP,
    output logic                  s2m_RLAST,
    output logic [USER_WIDTH-1:0] s2m_RUSER,
    input  logic                  s2m_RREADY,
    // slave 0
    output logic [ID_WIDTH-1:0]   m0_ARID,
    output logic [ADDR_WIDTH-1:0] m0_ARADDR,
    output logic [7:0]            m0_ARLEN,
    output logic [2:0]            m0_ARSIZE,
    output logic [1:0]            m0_ARBURST,
    output logic                  m0_ARLOCK,
    output logic [3:0]            m0_ARCACHE,
    output logic [2:0]            m0_ARPROT,
    output logic [3:0]            m0_ARQOS,
    output logic [3:0]            m0_ARREGION,
    output logic [USER_WIDTH-1:0] m0_ARUSER,
    output logic                  m0_ARVALID,
    input  logic                  m0_ARREADY,
    input  logic                  m0_RVALID,
    input  logic [ID_WIDTH-1:0]   m0_RID,
    input  logic [DATA_WIDTH-1:0] m0_RDATA,
    input  logic [1:0]            m0_RRESP,
    input  logic                  m0_RLAST,
    input  logic [USER_WIDTH-1:0] m0_RUSER,
    output logic                  m0_RREADY,
    // slave 1
    output logic [ID_WIDTH-1:0]   m1_ARID,
    output logic [ADDR_WIDTH-1:0] m1_ARADDR,
    output logic [7:0]            m1_ARLEN,
    output logic [2:0]            m1_ARSIZE,
    output logic [1:0]            m1_ARBURST,
    output logic                  m1_ARLOCK,
    output logic [3:0]            m1_ARCACHE,
    output logic [2:0]            m1_ARPROT,
    output logic [3:0]            m1_ARQOS,
    output logic [3:0]            m1_ARREGION,
    output logic [USER_WIDTH-1:0] m1_ARUSER,
    output logic                  m1_ARVALID,
    input  logic                  m1_ARREADY,
    input  logic                  m1_RVALID,
    input  logic [ID_WIDTH-1:0]   m1_RID,
    input  logic [DATA_WIDTH-1:0] m1_RDATA,
    input  logic [1:0]            m1_RRESP,
    input  logic                  m1_RLAST,
    input  logic [USER_WIDTH-1:0] m1_RUSER,
    output logic                  m1_RREADY,
    // slave 2
    output logic [ID_WIDTH-1:0]   m2_ARID,
    output logic [ADDR_WIDTH-1:0] m2_ARADDR,
    output logic [7:0]            m2_ARLEN,
    output logic [2:0]            m2_ARSIZE,
    output logic [1:0]            m2_ARBURST,
    output logic                  m2_ARLOCK,
    output logic [3:0]            m2_ARCACHE,
    output logic [2:0]            m2_ARPROT,
    output logic [3:0]            m2_ARQOS,
    output logic [3:0]            m2_ARREGION,
    output logic [USER_WIDTH-1:0] m2_ARUSER,
    output logic                  m2_ARVALID,
    input  logic                  m2_ARREADY,
    input  logic                  m2_RVALID,
    input  logic [ID_WIDTH-1:0]   m2_RID,
    input  logic [DATA_WIDTH-1:0] m2_RDATA,
    input  logic [1:0]            m2_RRESP,
    input  logic                  m2_RLAST,
    input  logic [USER_WIDTH-1:0] m2_RUSER,
    output logic                  m2_RREADY,
    // slave 3
    output logic [ID_WIDTH-1:0]   m3_ARID,
    output logic [ADDR_WIDTH-1:0] m3_ARADDR,
    output logic [7:0]            m3_ARLEN,
    output logic [2:0]            m3_ARSIZE,
    output logic [1:0]            m3_ARBURST,
    output logic                  m3_ARLOCK,
    output logic [3:0]            m3_ARCACHE,
    output logic [2:0]            m3_ARPROT,
    output logic [3:0]            m3_ARQOS,
    output logic [3:0]            m3_ARREGION,
    output logic [USER_WIDTH-1:0] m3_ARUSER,
    output logic                  m3_ARVALID,
    input  logic                  m3_ARREADY,
    input  logic                  m3_RVALID,
    input  logic [ID_WIDTH-1:0]   m3_RID,
    input  logic [DATA_WIDTH-1:0] m3_RDATA,
    input  logic [1:0]            m3_RRESP,
    input  logic                  m3_RLAST,
    input  logic [USER_WIDTH-1:0] m3_RUSER,
    output logic                  m3_RREADY
);

    // AR payload: ID, ADDR, LEN, SIZE, BURST, LOCK, CACHE, PROT, QOS, REGION, USER
    localparam int ARP_W = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + USER_WIDTH;
    // R payload: ID, DATA, RESP, LAST, USER
    localparam int RP_W  = ID_WIDTH + DATA_WIDTH + 2 + 1 + USER_WIDTH;

    state_e                state_q;
    logic [1:0]            sel_q;
    logic                  hit_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [7:0]            len_q;
    logic [7:0]            cnt_q;

    logic [1:0]            dec_sel;
    logic                  dec_hit;
    logic                  derr_last;

    logic [ARP_W-1:0]      ar_pay;
    logic [ARP_W-1:0]      ar_out [NUM_SLV];
    logic [RP_W-1:0]       r_in   [NUM_SLV];
    logic [RP_W-1:0]       r_out;
    logic [NUM_SLV-1:0]    m_arready;
    logic [NUM_SLV-1:0]    m_rvalid;
    logic [NUM_SLV-1:0]    m_arvalid;
    logic [NUM_SLV-1:0]    m_rready;

    axi_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .S0_BASE    (S0_BASE),
        .S1_BASE    (S1_BASE),
        .S2_BASE    (S2_BASE),
        .S3_BASE    (S3_BASE),
        .S0_MASK    (S0_MASK),
        .S1_MASK    (S1_MASK),
        .S2_MASK    (S2_MASK),
        .S3_MASK    (S3_MASK)
    ) u_dec (
        .addr_i (s2m_ARADDR),
        .sel_o  (dec_sel),
        .hit_o  (dec_hit)
    );

    assign ar_pay = {s2m_ARID, s2m_ARADDR, s2m_ARLEN, s2m_ARSIZE, s2m_ARBURST, s2m_ARLOCK,
                     s2m_ARCACHE, s2m_ARPROT, s2m_ARQOS, s2m_ARREGION, s2m_ARUSER};

    assign {m0_ARID, m0_ARADDR, m0_ARLEN, m0_ARSIZE, m0_ARBURST, m0_ARLOCK,
            m0_ARCACHE, m0_ARPROT, m0_ARQOS, m0_ARREGION, m0_ARUSER} = ar_out[0];
    assign {m1_ARID, m1_ARADDR, m1_ARLEN, m1_ARSIZE, m1_ARBURST, m1_ARLOCK,
            m1_ARCACHE, m1_ARPROT, m1_ARQOS, m1_ARREGION, m1_ARUSER} = ar_out[1];
    assign {m2_ARID, m2_ARADDR, m2_ARLEN, m2_ARSIZE, m2_ARBURST, m2_ARLOCK,
            m2_ARCACHE, m2_ARPROT, m2_ARQOS, m2_ARREGION, m2_ARUSER} = ar_out[2];
    assign {m3_ARID, m3_ARADDR, m3_ARLEN, m3_ARSIZE, m3_ARBURST, m3_ARLOCK,
            m3_ARCACHE, m3_ARPROT, m3_ARQOS, m3_ARREGION, m3_ARUSER} = ar_out[3];

    assign r_in[0] = {m0_RID, m0_RDATA, m0_RRESP, m0_RLAST, m0_RUSER};
    assign r_in[1] = {m1_RID, m1_RDATA, m1_RRESP, m1_RLAST, m1_RUSER};
    assign r_in[2] = {m2_RID, m2_RDATA, m2_RRESP, m2_RLAST, m2_RUSER};
    assign r_in[3] = {m3_RID, m3_RDATA, m3_RRESP, m3_RLAST, m3_RUSER};

    assign m_arready = {m3_ARREADY, m2_ARREADY, m1_ARREADY, m0_ARREADY};
    assign m_rvalid  = {m3_RVALID,  m2_RVALID,  m1_RVALID,  m0_RVALID};

    assign {m3_ARVALID, m2_ARVALID, m1_ARVALID, m0_ARVALID} = m_arvalid;
    assign {m3_RREADY,  m2_RREADY,  m1_RREADY,  m0_RREADY}  = m_rready;

    assign {s2m_RID, s2m_RDATA, s2m_RRESP, s2m_RLAST, s2m_RUSER} = r_out;

    assign derr_last = (cnt_q == len_q);

    // Output routing is a pure function of state and latched select, so an async
    // reset drops every output to zero immediately.
    always_comb begin
        m_arvalid   = '0;
        m_rready    = '0;
        s2m_ARREADY = 1'b0;
        s2m_RVALID  = 1'b0;
        r_out       = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            ar_out[k] = '0;
        end
        case (state_q)
            ADDR: begin
                if (hit_q) begin
                    m_arvalid[sel_q] = s2m_ARVALID;
                    ar_out[sel_q]    = ar_pay;
                    s2m_ARREADY      = m_arready[sel_q];
                end else begin
                    s2m_ARREADY = 1'b1;
                end
            end
            DATA: begin
                s2m_RVALID      = m_rvalid[sel_q];
                r_out           = r_in[sel_q];
                m_rready[sel_q] = s2m_RREADY;
            end
            DERR: begin
                s2m_RVALID = 1'b1;
                r_out      = {id_q, {DATA_WIDTH{1'b0}}, RESP_DECERR, derr_last, {USER_WIDTH{1'b0}}};
            end
            default: ;
        endcase
    end

    // Transaction sequencer: decode, address handshake, data routing or DECERR beats.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            hit_q   <= 1'b0;
            id_q    <= '0;
            len_q   <= 8'd0;
            cnt_q   <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s2m_ARVALID) begin
                        sel_q   <= dec_sel;
                        hit_q   <= dec_hit;
                        id_q    <= s2m_ARID;
                        len_q   <= s2m_ARLEN;
                        cnt_q   <= 8'd0;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (!hit_q) begin
                        state_q <= DERR;
                    end else if (s2m_ARVALID && m_arready[sel_q]) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (s2m_RVALID && s2m_RREADY && s2m_RLAST) begin
                        state_q <= IDLE;
                    end
                end
                DERR: begin
                    if (s2m_RREADY) begin
                        if (derr_last) begin
                            cnt_q   <= 8'd0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slave_demux_r.sv
// Directed bench for the read-channel demux with hand-computed expectations.
module tb_axi_slave_demux_r;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]    s_arid;
    logic [63:0]   s_araddr;
    logic [7:0]    s_arlen;
    logic [2:0]    s_arsize;
    logic [1:0]    s_arburst;
    logic          s_arlock;
    logic [3:0]    s_arcache;
    logic [2:0]    s_arprot;
    logic [3:0]    s_arqos;
    logic [3:0]    s_arregion;
    logic [7:0]    s_aruser;
    logic          s_arvalid;
    logic          s_arready;
    logic          s_rvalid;
    logic [7:0]    s_rid;
    logic [1023:0] s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rlast;
    logic [7:0]    s_ruser;
    logic          s_rready;

    logic [7:0]    m_arid     [4];
    logic [63:0]   m_araddr   [4];
    logic [7:0]    m_arlen    [4];
    logic [2:0]    m_arsize   [4];
    logic [1:0]    m_arburst  [4];
    logic          m_arlock   [4];
    logic [3:0]    m_arcache  [4];
    logic [2:0]    m_arprot   [4];
    logic [3:0]    m_arqos    [4];
    logic [3:0]    m_arregion [4];
    logic [7:0]    m_aruser   [4];
    logic          m_arvalid  [4];
    logic          m_arready  [4];
    logic          m_rvalid   [4];
    logic [7:0]    m_rid      [4];
    logic [1023:0] m_rdata    [4];
    logic [1:0]    m_rresp    [4];
    logic          m_rlast    [4];
    logic [7:0]    m_ruser    [4];
    logic          m_rready   [4];

    wire [3:0] arv_vec = {m_arvalid[3], m_arvalid[2], m_arvalid[1], m_arvalid[0]};
    wire [3:0] rr_vec  = {m_rready[3], m_rready[2], m_rready[1], m_rready[0]};

    int total = 0;
    int bad   = 0;

    axi_slave_demux_r dut (
        .clk(clk), .rstn(rstn),
        .s2m_ARID(s_arid), .s2m_ARADDR(s_araddr), .s2m_ARLEN(s_arlen), .s2m_ARSIZE(s_arsize),
        .s2m_ARBURST(s_arburst), .s2m_ARLOCK(s_arlock), .s2m_ARCACHE(s_arcache),
        .s2m_ARPROT(s_arprot), .s2m_ARQOS(s_arqos), .s2m_ARREGION(s_arregion),
        .s2m_ARUSER(s_aruser), .s2m_ARVALID(s_arvalid), .s2m_ARREADY(s_arready),
        .s2m_RVALID(s_rvalid), .s2m_RID(s_rid), .s2m_RDATA(s_rdata), .s2m_RRESP(s_rresp),
        .s2m_RLAST(s_rlast), .s2m_RUSER(s_ruser), .s2m_RREADY(s_rready),
        .m0_ARID(m_arid[0]), .m0_ARADDR(m_araddr[0]), .m0_ARLEN(m_arlen[0]), .m0_ARSIZE(m_arsize[0]),
        .m0_ARBURST(m_arburst[0]), .m0_ARLOCK(m_arlock[0]), .m0_ARCACHE(m_arcache[0]),
        .m0_ARPROT(m_arprot[0]), .m0_ARQOS(m_arqos[0]), .m0_ARREGION(m_arregion[0]),
        .m0_ARUSER(m_aruser[0]), .m0_ARVALID(m_arvalid[0]), .m0_ARREADY(m_arready[0]),
        .m0_RVALID(m_rvalid[0]), .m0_RID(m_rid[0]), .m0_RDATA(m_rdata[0]), .m0_RRESP(m_rresp[0]),
        .m0_RLAST(m_rlast[0]), .m0_RUSER(m_ruser[0]), .m0_RREADY(m_rready[0]),
        .m1_ARID(m_arid[1]), .m1_ARADDR(m_araddr[1]), .m1_ARLEN(m_arlen[1]), .m1_ARSIZE(m_arsize[1]),
        .m1_ARBURST(m_arburst[1]), .m1_ARLOCK(m_arlock[1]), .m1_ARCACHE(m_arcache[1]),
        .m1_ARPROT(m_arprot[1]), .m1_ARQOS(m_arqos[1]), .m1_ARREGION(m_arregion[1]),
        .m1_ARUSER(m_aruser[1]), .m1_ARVALID(m_arvalid[1]), .m1_ARREADY(m_arready[1]),
        .m1_RVALID(m_rvalid[1]), .m1_RID(m_rid[1]), .m1_RDATA(m_rdata[1]), .m1_RRESP(m_rresp[1]),
        .m1_RLAST(m_rlast[1]), .m1_RUSER(m_ruser[1]), .m1_RREADY(m_rready[1]),
        .m2_ARID(m_arid[2]), .m2_ARADDR(m_araddr[2]), .m2_ARLEN(m_arlen[2]), .m2_ARSIZE(m_arsize[2]),
        .m2_ARBURST(m_arburst[2]), .m2_ARLOCK(m_arlock[2]), .m2_ARCACHE(m_arcache[2]),
        .m2_ARPROT(m_arprot[2]), .m2_ARQOS(m_arqos[2]), .m2_ARREGION(m_arregion[2]),
        .m2_ARUSER(m_aruser[2]), .m2_ARVALID(m_arvalid[2]), .m2_ARREADY(m_arready[2]),
        .m2_RVALID(m_rvalid[2]), .m2_RID(m_rid[2]), .m2_RDATA(m_rdata[2]), .m2_RRESP(m_rresp[2]),
        .m2_RLAST(m_rlast[2]), .m2_RUSER(m_ruser[2]), .m2_RREADY(m_rready[2]),
        .m3_ARID(m_arid[3]), .m3_ARADDR(m_araddr[3]), .m3_ARLEN(m_arlen[3]), .m3_ARSIZE(m_arsize[3]),
        .m3_ARBURST(m_arburst[3]), .m3_ARLOCK(m_arlock[3]), .m3_ARCACHE(m_arcache[3]),
        .m3_ARPROT(m_arprot[3]), .m3_ARQOS(m_arqos[3]), .m3_ARREGION(m_arregion[3]),
        .m3_ARUSER(m_aruser[3]), .m3_ARVALID(m_arvalid[3]), .m3_ARREADY(m_arready[3]),
        .m3_RVALID(m_rvalid[3]), .m3_RID(m_rid[3]), .m3_RDATA(m_rdata[3]), .m3_RRESP(m_rresp[3]),
        .m3_RLAST(m_rlast[3]), .m3_RUSER(m_ruser[3]), .m3_RREADY(m_rready[3])
    );

    task automatic chk(input string tag, input logic [1023:0] act, input logic [1023:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Present an AR, check the decode cycle and the forwarded AR, then drop ARVALID.
    // Returns at the negedge where the FSM sits in DATA or DERR.
    task automatic issue_ar(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input int exp_sel);
        @(negedge clk);
        s_arid = id; s_araddr = addr; s_arlen = len; s_aruser = 8'hA5; s_arvalid = 1'b1;
        #1;
        chk("idle_arready", s_arready, 0);
        chk("idle_arvalid", arv_vec, 0);
        @(negedge clk);
        #1;
        if (exp_sel >= 0) begin
            chk("addr_arvalid", arv_vec, 4'(1 << exp_sel));
            chk("addr_araddr", m_araddr[exp_sel], addr);
            chk("addr_arid", m_arid[exp_sel], id);
            chk("addr_arlen", m_arlen[exp_sel], len);
            chk("addr_aruser", m_aruser[exp_sel], 8'hA5);
            chk("unsel_araddr", m_araddr[(exp_sel + 1) % 4], 0);
        end else begin
            chk("miss_arvalid", arv_vec, 0);
        end
        chk("addr_arready", s_arready, 1);
        @(negedge clk);
        s_arvalid = 1'b0; s_arid = '0; s_araddr = '0; s_arlen = '0; s_aruser = '0;
    endtask

    initial begin
        int beat;
        int last_at;
        logic rr;

        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = 3'd5; s_arburst = 2'd1;
        s_arlock = 1'b0; s_arcache = 4'h3; s_arprot = 3'h2; s_arqos = 4'h1; s_arregion = 4'h0;
        s_aruser = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_arready[k] = 1'b1; m_rvalid[k] = 1'b0; m_rid[k] = '0; m_rdata[k] = '0;
            m_rresp[k] = 2'b00; m_rlast[k] = 1'b0; m_ruser[k] = '0;
        end

        // Reset state
        #1;
        chk("rst_arready", s_arready, 0);
        chk("rst_rvalid", s_rvalid, 0);
        chk("rst_arvalid", arv_vec, 0);
        chk("rst_rready", rr_vec, 0);
        @(negedge clk);
        rstn = 1'b1;

        // Single beat to slave 2
        issue_ar(8'h05, 64'h2000_0040, 8'd0, 2);
        m_rvalid[2] = 1'b1; m_rid[2] = 8'h05; m_rdata[2] = 1024'h1234_5678 << 900;
        m_rlast[2] = 1'b1; m_ruser[2] = 8'h3C; s_rready = 1'b1;
        #1;
        chk("t1_rvalid", s_rvalid, 1);
        chk("t1_rid", s_rid, 8'h05);
        chk("t1_rdata", s_rdata, 1024'h1234_5678 << 900);
        chk("t1_rlast", s_rlast, 1);
        chk("t1_ruser", s_ruser, 8'h3C);
        chk("t1_rready", rr_vec, 4'b0100);
        @(negedge clk);
        #1;
        chk("t1_idle_rvalid", s_rvalid, 0);
        chk("t1_idle_rready", rr_vec, 0);
        m_rvalid[2] = 1'b0; m_rlast[2] = 1'b0; m_ruser[2] = '0; s_rready = 1'b0;

        // 4-beat burst to slave 0 with RREADY toggling
        issue_ar(8'h21, 64'h0000_0100, 8'd3, 0);
        beat = 0;
        for (int cyc = 0; cyc < 20 && beat < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            rr = (cyc % 2 == 0);
            s_rready = rr;
            m_rvalid[0] = 1'b1; m_rid[0] = 8'h21;
            m_rdata[0] = (1024'(beat + 1) << 1000) | 1024'(beat + 1);
            m_rlast[0] = (beat == 3);
            #1;
            chk("t2_rvalid", s_rvalid, 1);
            chk("t2_rdata", s_rdata, (1024'(beat + 1) << 1000) | 1024'(beat + 1));
            chk("t2_rlast", s_rlast, beat == 3);
            chk("t2_rready", m_rready[0], rr);
            if (rr) beat++;
        end
        chk("t2_beats", beat, 4);
        @(negedge clk);
        s_rready = 1'b1;
        #1;
        chk("t2_idle_rvalid", s_rvalid, 0);
        chk("t2_idle_rready", m_rready[0], 0);
        m_rvalid[0] = 1'b0; m_rlast[0] = 1'b0; s_rready = 1'b0;

        // Decode error, ARLEN=3, one stall cycle
        issue_ar(8'h09, 64'h4000_0000, 8'd3, -1);
        beat = 0;
        for (int cyc = 0; cyc < 12 && beat < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            rr = (cyc != 1);
            s_rready = rr;
            #1;
            chk("t3_rvalid", s_rvalid, 1);
            chk("t3_rresp", s_rresp, 2'b11);
            chk("t3_rdata", s_rdata, 0);
            chk("t3_rid", s_rid, 8'h09);
            chk("t3_rlast", s_rlast, beat == 3);
            chk("t3_rready_slaves", rr_vec, 0);
            if (rr) beat++;
        end
        chk("t3_beats", beat, 4);
        @(negedge clk);
        #1;
        chk("t3_idle_rvalid", s_rvalid, 0);
        s_rready = 1'b0;

        // Stray RVALID from slave 3 during a 2-beat burst to slave 1
        m_rvalid[3] = 1'b1; m_rid[3] = 8'hEE; m_rdata[3] = 1024'hDEAD; m_rlast[3] = 1'b1;
        issue_ar(8'h11, 64'h1000_0100, 8'd1, 1);
        for (int b = 0; b < 2; b++) begin
            if (b > 0) @(negedge clk);
            s_rready = 1'b1;
            m_rvalid[1] = 1'b1; m_rid[1] = 8'h11; m_rdata[1] = 1024'(16'hB100 + b);
            m_rlast[1] = (b == 1);
            #1;
            chk("t4_rdata", s_rdata, 1024'(16'hB100 + b));
            chk("t4_rid", s_rid, 8'h11);
            chk("t4_m3_rready", m_rready[3], 0);
            chk("t4_m1_rready", m_rready[1], 1);
        end
        @(negedge clk);
        #1;
        chk("t4_idle_rvalid", s_rvalid, 0);
        m_rvalid[1] = 1'b0; m_rlast[1] = 1'b0; m_rvalid[3] = 1'b0; m_rlast[3] = 1'b0;
        s_rready = 1'b0;

        // Reset during beat 2 of an 8-beat burst to slave 2
        issue_ar(8'h42, 64'h2000_1000, 8'd7, 2);
        s_rready = 1'b1;
        m_rvalid[2] = 1'b1; m_rid[2] = 8'h42; m_rdata[2] = 1024'h10; m_rlast[2] = 1'b0;
        #1;
        chk("t5_beat1", s_rdata, 1024'h10);
        @(negedge clk);
        m_rdata[2] = 1024'h11;
        #1;
        chk("t5_beat2", s_rdata, 1024'h11);
        rstn = 1'b0;
        #1;
        chk("t5_rst_rvalid", s_rvalid, 0);
        chk("t5_rst_rdata", s_rdata, 0);
        chk("t5_rst_rid", s_rid, 0);
        chk("t5_rst_rready", rr_vec, 0);
        chk("t5_rst_arready", s_arready, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("t5_post_rvalid", s_rvalid, 0);
        chk("t5_post_rready", rr_vec, 0);
        m_rvalid[2] = 1'b0; m_rdata[2] = '0; s_rready = 1'b0;
        issue_ar(8'h33, 64'h1000_0008, 8'd0, 1);
        m_rvalid[1] = 1'b1; m_rid[1] = 8'h33; m_rdata[1] = 1024'h77; m_rlast[1] = 1'b1;
        s_rready = 1'b1;
        #1;
        chk("t5_new_rdata", s_rdata, 1024'h77);
        chk("t5_new_rlast", s_rlast, 1);
        @(negedge clk);
        #1;
        chk("t5_new_idle", s_rvalid, 0);
        m_rvalid[1] = 1'b0; m_rlast[1] = 1'b0; s_rready = 1'b0;

        // DECERR with ARLEN=255: 256 beats, RLAST only on the last one
        issue_ar(8'h77, 64'h8000_0000, 8'd255, -1);
        s_rready = 1'b1;
        last_at = -1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (!s_rvalid) break;
            if (s_rlast) begin
                last_at = cyc;
                break;
            end
        end
        chk("t6_last_index", last_at, 255);
        @(negedge clk);
        #1;
        chk("t6_idle_rvalid", s_rvalid, 0);
        s_rready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
